// File: rtl/key_event_queue_pkg.sv
// key_event_queue_pkg: shared keypad code constants and the legal-code check.
package key_event_queue_pkg;
    localparam int         KEY_CODE_W  = 4;
    localparam logic [1:0] ROW_ILLEGAL = 2'b11;
    localparam logic [1:0] COL_ILLEGAL = 2'b11;

    function automatic logic key_legal(input logic [3:0] code);
        return (code[3:2] != ROW_ILLEGAL) && (code[1:0] != COL_ILLEGAL);
    endfunction
endpackage

// File: rtl/key_sync_edge.sv
// key_sync_edge: 2-flop synchronizer for the keypad outputs plus press-edge detection.
module key_sync_edge
    import key_event_queue_pkg::*;
#(
    parameter int KEY_W = KEY_CODE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_key,
    input  logic [KEY_W-1:0] key,
    output logic             press,
    output logic [KEY_W-1:0] key_s
);
    logic             vk_m_q, vk_s_q, vk_d_q, armed_q;
    logic             vk_m_d, vk_s_d, vk_d_d, armed_d;
    logic [KEY_W-1:0] key_m_q, key_s_q, key_m_d, key_s_d;

    // While unarmed, vk_d tracks the value vk_s is about to take, so a key
    // held through reset never looks like a fresh rising edge.
    always_comb begin
        vk_m_d  = valid_key;
        key_m_d = key;
        key_s_d = key_m_q;
        vk_s_d  = vk_m_q;
        vk_d_d  = armed_q ? vk_s_q : vk_m_q;
        armed_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        vk_m_q  <= vk_m_d;
        key_m_q <= key_m_d;
        key_s_q <= key_s_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vk_s_q  <= 1'b0;
            vk_d_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            vk_s_q  <= vk_s_d;
            vk_d_q  <= vk_d_d;
            armed_q <= armed_d;
        end
    end

    assign press = vk_s_q & ~vk_d_q & armed_q;
    assign key_s = key_s_q;
endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: turns synchronized key presses into FIFO-queued events
// drained by a valid/ready handshake, with reject and sticky overflow flags.
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int KEY_W = KEY_CODE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_key,
    input  logic [KEY_W-1:0]         key,
    output logic                     ev_valid,
    output logic [KEY_W-1:0]         ev_key,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     rejected
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic             press, legal, push_req, push, pop, full, drop;
    logic [KEY_W-1:0] key_s;
    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d, rejected_q, rejected_d;

    key_sync_edge #(.KEY_W(KEY_W)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .valid_key (valid_key),
        .key       (key),
        .press     (press),
        .key_s     (key_s)
    );

    // A full queue still accepts a push when the head leaves on the same edge.
    always_comb begin
        legal      = key_legal(key_s[3:0]);
        push_req   = press & legal;
        pop        = (count_q != '0) & ev_ready;
        full       = count_q == CW'(DEPTH);
        push       = push_req & (~full | pop);
        drop       = push_req & full & ~pop;
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        overflow_d = drop | (overflow_q & ~clr_overflow);
        rejected_d = press & ~legal;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= key_s;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rejected_q <= rejected_d;
        end
    end

    assign ev_valid = count_q != '0;
    assign ev_key   = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rejected = rejected_q;
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: directed and randomized checks of key_event_queue
// against a queue-based reference model of press/pop/overflow behaviour.
module tb_key_event_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, valid_key, ev_ready, clr_overflow;
    logic [3:0] key;
    logic       ev_valid, overflow, rejected;
    logic [3:0] ev_key;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    logic [3:0] mq[$];
    logic       m_ov;

    key_event_queue #(.DEPTH(DEPTH), .KEY_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_key    (valid_key),
        .key          (key),
        .ev_valid     (ev_valid),
        .ev_key       (ev_key),
        .ev_ready     (ev_ready),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .rejected     (rejected)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_legal(input logic [3:0] c);
        return (c / 4) < 3 && (c % 4) < 3;
    endfunction

    task automatic do_reset();
        reset = 1'b0; valid_key = 1'b0; ev_ready = 1'b0; clr_overflow = 1'b0; key = '0;
        repeat (3) tick();
        reset = 1'b1;
        mq.delete();
        m_ov = 1'b0;
    endtask

    task automatic press_hold(input logic [3:0] c, output logic rej);
        key = c; valid_key = 1'b1; rej = 1'b0;
        repeat (4) begin tick(); rej |= rejected; end
        valid_key = 1'b0;
        repeat (4) begin tick(); rej |= rejected; end
    endtask

    task automatic model_press(input logic [3:0] c);
        if (is_legal(c)) begin
            if (mq.size() < DEPTH) mq.push_back(c);
            else m_ov = 1'b1;
        end
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ev_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 || rejected !== 1'b0) begin
            errors++;
            $display("FAIL reset: ev_valid=%b count=%0d overflow=%b rejected=%b, want 0 0 0 0",
                     ev_valid, count, overflow, rejected);
        end
    endtask

    task automatic test_single_press();
        int extra = 0;
        do_reset();
        key = 4'b0101; valid_key = 1'b1;
        tick(); tick();
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL press_early: ev_valid=%b want 0", ev_valid); end
        tick();
        checks++;
        if (ev_valid !== 1'b1 || ev_key !== 4'b0101 || count !== 3'd1) begin
            errors++;
            $display("FAIL press_latency: ev_valid=%b ev_key=%b count=%0d want 1 0101 1", ev_valid, ev_key, count);
        end
        repeat (97) begin tick(); if (count !== 3'd1) extra++; end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL press_held: %0d cycles with count!=1, want 0", extra); end
        valid_key = 1'b0;
        repeat (5) tick();
        checks++;
        if (count !== 3'd1) begin errors++; $display("FAIL release: count=%0d want 1", count); end
    endtask

    task automatic test_reject();
        do_reset();
        key = 4'b1100; valid_key = 1'b1;
        tick(); tick();
        checks++;
        if (rejected !== 1'b0) begin errors++; $display("FAIL reject_early: rejected=%b want 0", rejected); end
        tick();
        checks++;
        if (rejected !== 1'b1) begin errors++; $display("FAIL reject_pulse: rejected=%b want 1", rejected); end
        tick();
        checks++;
        if (rejected !== 1'b0 || count !== 3'd0 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL reject_after: rejected=%b count=%0d ev_valid=%b want 0 0 0", rejected, count, ev_valid);
        end
        valid_key = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_overflow();
        logic       r;
        logic [3:0] codes[5] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5};
        do_reset();
        foreach (codes[i]) press_hold(codes[i], r);
        checks++;
        if (count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_fill: count=%0d overflow=%b want 4 1", count, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || ev_key !== codes[i]) begin
                errors++;
                $display("FAIL drain_%0d: ev_valid=%b ev_key=%0d want 1 %0d", i, ev_valid, ev_key, codes[i]);
            end
            pop_one();
        end
        checks++;
        if (ev_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: ev_valid=%b count=%0d want 0 0", ev_valid, count);
        end
        pop_one();
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL pop_empty: count=%0d want 0", count); end
    endtask

    task automatic test_full_push_pop();
        logic       r;
        logic [3:0] exp_q[4] = '{4'd1, 4'd2, 4'd4, 4'd8};
        do_reset();
        press_hold(4'd0, r); press_hold(4'd1, r); press_hold(4'd2, r); press_hold(4'd4, r);
        key = 4'd8; valid_key = 1'b1;
        tick(); tick();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++;
        if (count !== 3'd4 || overflow !== 1'b0 || ev_key !== 4'd1) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d overflow=%b head=%0d want 4 0 1", count, overflow, ev_key);
        end
        valid_key = 1'b0;
        repeat (4) tick();
        // Queue is full again with 1,2,4,8: a drop with clr_overflow on the same edge.
        key = 4'd9; valid_key = 1'b1;
        tick(); tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL set_wins: overflow=%b count=%0d want 1 4", overflow, count);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: overflow=%b want 0", overflow); end
        valid_key = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || ev_key !== exp_q[i]) begin
                errors++;
                $display("FAIL full_drain_%0d: ev_valid=%b ev_key=%0d want 1 %0d", i, ev_valid, ev_key, exp_q[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_reset_held();
        logic r;
        int   bad = 0;
        do_reset();
        press_hold(4'd0, r);
        key = 4'd5; valid_key = 1'b1;
        repeat (4) tick();
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL held_pre: count=%0d want 2", count); end
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        checks++;
        if (count !== 3'd0 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL held_reset: count=%0d ev_valid=%b want 0 0", count, ev_valid);
        end
        repeat (10) begin tick(); if (count !== 3'd0) bad++; end
        valid_key = 1'b0;
        repeat (4) begin tick(); if (count !== 3'd0) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL held_no_event: %0d cycles nonzero count, want 0", bad); end
        press_hold(4'd5, r);
        checks++;
        if (count !== 3'd1 || ev_key !== 4'd5) begin
            errors++;
            $display("FAIL held_repress: count=%0d ev_key=%0d want 1 5", count, ev_key);
        end
    endtask

    task automatic test_random();
        logic       r;
        logic [3:0] c;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    c = 4'($urandom_range(0, 15));
                    press_hold(c, r);
                    model_press(c);
                    checks++;
                    if (r !== !is_legal(c)) begin
                        errors++;
                        $display("FAIL rnd_reject code=%0d: rejected_seen=%b want %b", c, r, !is_legal(c));
                    end
                end
                5, 6, 7, 8: begin
                    if (mq.size() > 0) begin
                        checks++;
                        if (ev_key !== mq[0]) begin
                            errors++;
                            $display("FAIL rnd_head: ev_key=%0d want %0d", ev_key, mq[0]);
                        end
                        void'(mq.pop_front());
                    end
                    pop_one();
                end
                default: begin
                    clr_overflow = 1'b1;
                    tick();
                    clr_overflow = 1'b0;
                    m_ov = 1'b0;
                end
            endcase
            checks++;
            if (count !== 3'(mq.size()) || overflow !== m_ov || ev_valid !== (mq.size() > 0)) begin
                errors++;
                $display("FAIL rnd_state step %0d: count=%0d overflow=%b ev_valid=%b want %0d %b %b",
                         n, count, overflow, ev_valid, mq.size(), m_ov, mq.size() > 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_reject();
        test_overflow();
        test_full_push_pop();
        test_reset_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
